// File: rtl/game_pkg.sv
// Shared game types: player heading encoding used by movement, collision and control.
package game_pkg;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        RIGHT = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        UP    = 3'd4
    } directions;

endpackage : game_pkg

// File: rtl/turn_controller_if.sv
// Mouse/selection inputs and per-player heading outputs of the turn controller.
interface turn_controller_if #(
    parameter int N_PLAYERS = 2,
    parameter int SEL_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
);
    import game_pkg::*;

    logic                 game_active;
    logic                 sel_valid;
    logic [SEL_W-1:0]     sel_id;
    logic                 mouse_right;
    logic                 mouse_left;
    directions            direction [N_PLAYERS];
    logic                 tick;
    logic [N_PLAYERS-1:0] turn_strobe;

    modport master (
        output game_active, sel_valid, sel_id, mouse_right, mouse_left,
        input  direction, tick, turn_strobe
    );

    modport slave (
        input  game_active, sel_valid, sel_id, mouse_right, mouse_left,
        output direction, tick, turn_strobe
    );

endinterface : turn_controller_if

// File: rtl/turn_controller.sv
// Per-player heading controller: latches one click-driven turn per player and
// applies all pending turns on a common game tick.
module turn_controller
    import game_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int TICK_PERIOD = 32_500_000,
    parameter int SEL_W       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    turn_controller_if.slave   ctrl
);

    localparam int             CNT_W    = $clog2(TICK_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD - 1);

    logic                 r_prev_r;
    logic                 r_prev_l;
    logic [CNT_W-1:0]     r_cnt;
    directions            r_dir [N_PLAYERS];
    logic [N_PLAYERS-1:0] r_pend_valid;
    logic [N_PLAYERS-1:0] r_pend_cw;
    logic [N_PLAYERS-1:0] r_strobe;

    logic                 w_evt_r;
    logic                 w_evt_l;
    logic                 w_qual;
    logic                 w_tick;
    logic [N_PLAYERS-1:0] w_sel_hit;
    logic [N_PLAYERS-1:0] w_req;
    logic [N_PLAYERS-1:0] w_req_cw;

    function automatic directions turn(input directions cur, input logic cw);
        case (cur)
            WAIT:    turn = cw ? RIGHT : LEFT;
            RIGHT:   turn = cw ? DOWN  : UP;
            DOWN:    turn = cw ? LEFT  : RIGHT;
            LEFT:    turn = cw ? UP    : DOWN;
            UP:      turn = cw ? RIGHT : LEFT;
            default: turn = WAIT;
        endcase
    endfunction

    assign w_evt_r = ctrl.mouse_right & ~r_prev_r;
    assign w_evt_l = ctrl.mouse_left  & ~r_prev_l;
    // Simultaneous right+left rising edges cancel each other out.
    assign w_qual  = ctrl.sel_valid & ctrl.game_active & (int'(ctrl.sel_id) < N_PLAYERS)
                   & (w_evt_r ^ w_evt_l);
    assign w_tick  = (r_cnt == CNT_LAST) & ctrl.game_active;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        w_sel_hit = '0;
        w_req     = '0;
        w_req_cw  = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            w_sel_hit[i] = w_qual && (ctrl.sel_id == SEL_W'(i));
            // A click landing on the tick cycle bypasses the pending slot.
            w_req[i]     = w_sel_hit[i] | r_pend_valid[i];
            w_req_cw[i]  = w_sel_hit[i] ? w_evt_r : r_pend_cw[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_r     <= 1'b0;
            r_prev_l     <= 1'b0;
            r_cnt        <= '0;
            r_pend_valid <= '0;
            r_pend_cw    <= '0;
            r_strobe     <= '0;
            for (int i = 0; i < N_PLAYERS; i++) r_dir[i] <= WAIT;
        end else begin
            // Edge history tracks buttons even while halted: a held button never fires on resume.
            r_prev_r <= ctrl.mouse_right;
            r_prev_l <= ctrl.mouse_left;
            r_strobe <= '0;
            if (!ctrl.game_active) begin
                r_cnt        <= '0;
                r_pend_valid <= '0;
                for (int i = 0; i < N_PLAYERS; i++) r_dir[i] <= WAIT;
            end else if (w_tick) begin
                r_cnt        <= '0;
                r_pend_valid <= '0;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (w_req[i]) begin
                        r_dir[i]    <= turn(r_dir[i], w_req_cw[i]);
                        r_strobe[i] <= 1'b1;
                    end
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (w_sel_hit[i]) begin
                        r_pend_valid[i] <= 1'b1;
                        r_pend_cw[i]    <= w_evt_r;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_dir_out
        assign ctrl.direction[g] = r_dir[g];
    end
    assign ctrl.tick        = w_tick;
    assign ctrl.turn_strobe = r_strobe;

endmodule : turn_controller

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with TICK_PERIOD=4, N_PLAYERS=3.
module tb_turn_controller;
    import game_pkg::*;

    localparam int NP = 3;
    localparam int TP = 4;
    localparam int SW = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   m_cnt;   // bench's own model of the tick counter

    turn_controller_if #(.N_PLAYERS(NP), .SEL_W(SW)) tif ();

    turn_controller #(.N_PLAYERS(NP), .TICK_PERIOD(TP), .SEL_W(SW)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic a_rst;
        logic a_act;
        a_rst = rst;
        a_act = tif.game_active;
        @(posedge clk);
        #1;
        if (a_rst || !a_act) m_cnt = 0;
        else                 m_cnt = (m_cnt == TP - 1) ? 0 : m_cnt + 1;
    endtask

    task automatic go_to_cnt(input int n);
        for (int k = 0; k < 2 * TP && m_cnt != n; k++) step();
    endtask

    task automatic check_dirs(input string tag, input directions e0, input directions e1,
                              input directions e2);
        check({tag, "_d0"}, 32'(tif.direction[0]), 32'(e0));
        check({tag, "_d1"}, 32'(tif.direction[1]), 32'(e1));
        check({tag, "_d2"}, 32'(tif.direction[2]), 32'(e2));
    endtask

    directions cw_seq [4];
    int        n_wait;

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_cnt    = 0;
        rst             = 1'b1;
        tif.game_active = 1'b0;
        tif.sel_valid   = 1'b0;
        tif.sel_id      = '0;
        tif.mouse_right = 1'b0;
        tif.mouse_left  = 1'b0;
        #1;
        step();
        step();
        check_dirs("reset", WAIT, WAIT, WAIT);
        check("reset_strobe", 32'(tif.turn_strobe), 32'd0);
        check("reset_tick", 32'(tif.tick), 32'd0);
        rst = 1'b0;

        // Idle game: ticks every TP cycles at cnt 3, no turns.
        tif.game_active = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("idle_tick", 32'(tif.tick), 32'((c % TP) == TP - 1));
            check("idle_strobe", 32'(tif.turn_strobe), 32'd0);
            step();
        end
        check_dirs("idle", WAIT, WAIT, WAIT);

        // Held right click on player 0: exactly one turn.
        tif.sel_valid = 1'b1;
        tif.sel_id    = 2'd0;
        go_to_cnt(0);
        tif.mouse_right = 1'b1;
        go_to_cnt(3);
        check("p0_tick", 32'(tif.tick), 32'd1);
        check("p0_pre", 32'(tif.direction[0]), 32'(WAIT));
        step();
        check_dirs("p0_turn", RIGHT, WAIT, WAIT);
        check("p0_strobe", 32'(tif.turn_strobe), 32'b001);
        step();
        check("p0_strobe_drop", 32'(tif.turn_strobe), 32'd0);
        go_to_cnt(3);
        step();
        check("p0_hold_strobe", 32'(tif.turn_strobe), 32'd0);
        check("p0_hold_dir", 32'(tif.direction[0]), 32'(RIGHT));
        tif.mouse_right = 1'b0;

        // Player 1: left then right before one tick, latest wins.
        tif.sel_id = 2'd1;
        go_to_cnt(0);
        tif.mouse_left = 1'b1;
        step();
        tif.mouse_left = 1'b0;
        step();
        tif.mouse_right = 1'b1;
        step();
        tif.mouse_right = 1'b0;
        go_to_cnt(3);
        step();
        check("p1_latest", 32'(tif.direction[1]), 32'(RIGHT));
        check("p1_strobe", 32'(tif.turn_strobe), 32'b010);

        // Four clockwise turns walk the full compass.
        cw_seq = '{DOWN, LEFT, UP, RIGHT};
        for (int k = 0; k < 4; k++) begin
            go_to_cnt(0);
            tif.mouse_right = 1'b1;
            step();
            tif.mouse_right = 1'b0;
            go_to_cnt(3);
            step();
            check($sformatf("p1_cw%0d", k), 32'(tif.direction[1]), 32'(cw_seq[k]));
        end

        // Click player 2, then reselect 0 before the tick.
        tif.sel_id      = 2'd2;
        tif.mouse_right = 1'b1;
        step();
        tif.mouse_right = 1'b0;
        tif.sel_id      = 2'd0;
        go_to_cnt(3);
        step();
        check_dirs("p2_sel", RIGHT, RIGHT, RIGHT);
        check("p2_strobe", 32'(tif.turn_strobe), 32'b100);

        // Right and left rising together are discarded.
        go_to_cnt(0);
        tif.mouse_right = 1'b1;
        tif.mouse_left  = 1'b1;
        step();
        tif.mouse_right = 1'b0;
        tif.mouse_left  = 1'b0;
        go_to_cnt(3);
        step();
        check("both_strobe", 32'(tif.turn_strobe), 32'd0);
        check("both_dir", 32'(tif.direction[0]), 32'(RIGHT));

        // Out-of-range player index is ignored.
        tif.sel_id      = 2'd3;
        tif.mouse_left  = 1'b1;
        step();
        tif.mouse_left  = 1'b0;
        go_to_cnt(3);
        step();
        check("sel3_strobe", 32'(tif.turn_strobe), 32'd0);
        check_dirs("sel3", RIGHT, RIGHT, RIGHT);

        // Click rising on the tick cycle itself is applied through the bypass.
        tif.sel_id = 2'd1;
        go_to_cnt(3);
        tif.mouse_right = 1'b1;
        check("byp_tick", 32'(tif.tick), 32'd1);
        step();
        check("byp_dir", 32'(tif.direction[1]), 32'(DOWN));
        check("byp_strobe", 32'(tif.turn_strobe), 32'b010);
        tif.mouse_right = 1'b0;
        go_to_cnt(3);
        step();
        check("byp_next_strobe", 32'(tif.turn_strobe), 32'd0);
        check("byp_next_dir", 32'(tif.direction[1]), 32'(DOWN));

        // Halt with a pending turn, then resume with a button already held.
        tif.sel_id      = 2'd0;
        tif.mouse_right = 1'b1;
        step();
        tif.mouse_right = 1'b0;
        tif.game_active = 1'b0;
        step();
        check_dirs("halt", WAIT, WAIT, WAIT);
        check("halt_strobe", 32'(tif.turn_strobe), 32'd0);
        check("halt_tick", 32'(tif.tick), 32'd0);
        tif.mouse_left = 1'b1;
        step();
        tif.game_active = 1'b1;
        step();
        tif.mouse_left = 1'b0;
        go_to_cnt(3);
        check("resume_tick", 32'(tif.tick), 32'd1);
        step();
        check("resume_strobe", 32'(tif.turn_strobe), 32'd0);
        check_dirs("resume", WAIT, WAIT, WAIT);

        // Reset on a tick cycle with a pending turn.
        tif.sel_id      = 2'd2;
        tif.mouse_right = 1'b1;
        step();
        tif.mouse_right = 1'b0;
        go_to_cnt(3);
        check("rst_pre_tick", 32'(tif.tick), 32'd1);
        rst = 1'b1;
        step();
        check_dirs("rst_tick", WAIT, WAIT, WAIT);
        check("rst_tick_strobe", 32'(tif.turn_strobe), 32'd0);
        check("rst_tick_tick", 32'(tif.tick), 32'd0);
        rst = 1'b0;
        n_wait = 0;
        while (tif.tick !== 1'b1 && n_wait < 10) begin
            step();
            n_wait++;
        end
        check("rst_first_tick", 32'(n_wait), 32'(TP - 1));
        step();
        check("rst_pend_strobe", 32'(tif.turn_strobe), 32'd0);
        check("rst_pend_dir", 32'(tif.direction[2]), 32'(WAIT));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_turn_controller

// File: doc/turn_controller.md
# turn_controller

Parametrised per-player heading controller for the multi-player snake game. It converts left/right mouse clicks into relative turns (counter-clockwise/clockwise) of the currently selected player's heading. It latches one pending turn per player between movement ticks and applies all pending turns on a common game tick. The block sits between the mouse front end and the movement/collision logic, and drives each player's `directions` (game_pkg) heading.

## Interface
Parameters:
- N_PLAYERS, 2, number of independent players (≥1)
- TICK_PERIOD, 32_500_000, clk cycles per game tick (≥2)
- SEL_W, $clog2(N_PLAYERS) (min 1), width of sel_id

Ports:
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- game_active  in  1  0 = game halted: all headings WAIT, pending cleared, tick counter held at 0
- sel_valid  in  1  1 = sel_id addresses a player; 0 = clicks ignored
- sel_id  in  SEL_W  index of player receiving clicks; values ≥ N_PLAYERS are ignored
- mouse_right  in  1  right button level (clockwise turn)
- mouse_left  in  1  left button level (counter-clockwise turn)
- direction  out  directions [N_PLAYERS]  registered heading per player
- tick  out  1  one-cycle pulse on the final cycle of each tick period
- turn_strobe  out  N_PLAYERS  registered; bit i high for one cycle when direction[i] changed at the last tick

## Operation
- Edge detect: mouse_right and mouse_left are registered as r_prev and l_prev. evt_r = mouse_right & ~r_prev; evt_l = mouse_left & ~l_prev. Holding a button produces exactly one event.
- Event qualification: an event counts only when sel_valid=1, sel_id<N_PLAYERS and game_active=1.
  - evt_r & evt_l in the same cycle: both discarded; pending is unchanged.
- Pending slot per player: {pend_valid, pend_cw}.
  - A qualified event overwrites the selected player's slot (latest click wins): cw=1 for right, cw=0 for left.
  - Changing sel_id does not disturb other players' slots.
- Tick counter: cnt runs 0..TICK_PERIOD-1 while game_active=1. tick = (cnt==TICK_PERIOD-1) & game_active. cnt wraps to 0 after the tick cycle.
- On a tick cycle, for every player i, the effective request is:
  - a same-cycle qualified event for i, if present (bypass);
  - otherwise pend i, if valid.
  - If a request exists, direction[i] ← turn(direction[i], cw) and turn_strobe[i] ← 1 (the strobe is set even if the resulting heading is unchanged; it cannot be unchanged under this table). All slots are cleared.
- Turn table, given as current: cw / ccw:
  - WAIT: RIGHT / LEFT
  - RIGHT: DOWN / UP
  - DOWN: LEFT / RIGHT
  - LEFT: UP / DOWN
  - UP: RIGHT / LEFT
  - Any illegal encoding goes to WAIT.
- Non-tick cycles: directions hold; turn_strobe = 0.
- game_active=0:
  - Next cycle: all direction=WAIT, all slots cleared, cnt=0, tick=0, turn_strobe=0.
  - r_prev/l_prev keep tracking the buttons, so a button already held at resume produces no event.

## Timing
- Reset values (cycle after rst sampled high): direction[*]=WAIT, turn_strobe=0, cnt=0, pend_valid=0, r_prev=l_prev=0, tick=0.
- rst mid-operation overrides everything, including a coincident tick.
- Click to pending: a button rising in cycle k (evt high in k) sets pend_valid at edge k+1.
- Tick to heading: tick high in cycle t gives the new direction and turn_strobe visible in cycle t+1. turn_strobe drops in t+2.
- Tick spacing: exactly TICK_PERIOD cycles between consecutive tick pulses. The first tick comes TICK_PERIOD cycles after reset release or after game_active rises (cnt counts from 0).
- At most one turn per player per tick. Extra clicks before a tick overwrite each other.
- Pending set and tick clear in the same cycle: the tick consumes the bypassed event, and the slot ends cleared.

## Test plan
(TICK_PERIOD=4, N_PLAYERS=3)
- Reset then game_active=1, no clicks → direction all WAIT for 20 cycles; tick pulses at cycles 3, 7, 11 after enable; turn_strobe=0.
- sel_id=0, one right click, held for 10 cycles → at the next tick direction[0] goes WAIT→RIGHT. Later ticks leave it RIGHT (hold gives no repeat). turn_strobe=3'b001 for exactly one cycle.
- sel_id=1: left click, then right click, before the same tick → direction[1] WAIT→RIGHT (latest wins). Four cw clicks on successive ticks → RIGHT→DOWN→LEFT→UP→RIGHT.
- Click on player 2, change sel_id to 0 before the tick → direction[2] turns and direction[0] is unchanged. Right+left rising in the same cycle → no pending, no change. sel_id=3 click → ignored.
- Click rising exactly on the tick cycle → applied at that tick via bypass, and no second turn at the following tick.
- Mid-game game_active=0 → all WAIT next cycle, pending dropped. rst asserted on a tick cycle with a pending turn → all outputs hold reset values.
